// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
// - md_op_e: 4-bit op encoding, also driven by the controller from opcode/funct.
// - is_launch_op / is_read_op: op-class predicates.
// - Default busy-cycle counts.
// Optional feature macro: MD_UNIT_MADD_EN (MADD/MADDU/MSUB/MSUBU become launching ops).
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } md_op_e;

    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    // Ops that occupy the unit for multiple cycles.
    function automatic logic is_launch_op(md_op_e op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Ops that use the multiply timing rather than the divide timing.
    function automatic logic is_mul_op(md_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_read_op(md_op_e op);
        return (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage bus between the controller/datapath (master) and md_unit (slave).
// - start/op/a/b: launch request with forwarded rs/rt values.
// - busy: operation in flight (to the hazard controller).
// - hi/lo: architectural HI/LO; rd: MFHI/MFLO read data.
interface md_unit_if
    import md_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd;

    modport master (output start, op, a, b, input busy, hi, lo, rd);
    modport slave  (input start, op, a, b, output busy, hi, lo, rd);
endinterface

// File: rtl/md_calc.sv
// md_calc: combinational result generator for md_unit.
// - op, a, b: operation and operands.
// - hi_in, lo_in: current HI/LO (accumulator base for MADD/MSUB).
// - hi_out, lo_out: result to commit; wr: 1 when the result should be written
//   (0 for divide-by-zero and non-launching ops).
// Optional feature macro: MD_UNIT_MADD_EN.
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             wr
);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0]      s_prod, u_prod;
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0]        s_quo, s_rem, u_quo, u_rem;
    logic                    b_zero, s_ovf;

    // Sign-extend to 2*WIDTH first so the product is exact modulo 2^(2*WIDTH).
    assign s_prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign u_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign sa     = $signed(a);
    assign sb     = $signed(b);
    assign b_zero = (b == '0);
    // MOST_NEG / -1 overflows the quotient; pin the result explicitly.
    assign s_ovf  = (a == MOST_NEG) && (b == '1);

    always_comb begin
        s_quo = '0;
        s_rem = '0;
        u_quo = '0;
        u_rem = '0;
        if (!b_zero) begin
            s_quo = s_ovf ? MOST_NEG : WIDTH'(sa / sb);
            s_rem = s_ovf ? '0       : WIDTH'(sa % sb);
            u_quo = a / b;
            u_rem = a % b;
        end
    end

    always_comb begin
        hi_out = hi_in;
        lo_out = lo_in;
        wr     = 1'b0;
        case (op)
            OP_MULT:  begin {hi_out, lo_out} = s_prod;   wr = 1'b1;    end
            OP_MULTU: begin {hi_out, lo_out} = u_prod;   wr = 1'b1;    end
            OP_DIV:   begin hi_out = s_rem; lo_out = s_quo; wr = !b_zero; end
            OP_DIVU:  begin hi_out = u_rem; lo_out = u_quo; wr = !b_zero; end
`ifdef MD_UNIT_MADD_EN
            OP_MADD:  begin {hi_out, lo_out} = {hi_in, lo_in} + s_prod; wr = 1'b1; end
            OP_MADDU: begin {hi_out, lo_out} = {hi_in, lo_in} + u_prod; wr = 1'b1; end
            OP_MSUB:  begin {hi_out, lo_out} = {hi_in, lo_in} - s_prod; wr = 1'b1; end
            OP_MSUBU: begin {hi_out, lo_out} = {hi_in, lo_in} - u_prod; wr = 1'b1; end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// - clk, reset (async, active-low).
// - bus (md_unit_if.slave): start/op/a/b in; busy/hi/lo/rd out.
// The result is computed at launch and held in pending regs; a 4-bit
// down-counter models the latency and commits on the edge where it is 1.
// Optional feature macro: MD_UNIT_MADD_EN (MADD/MADDU/MSUB/MSUBU).
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    logic [3:0]       cnt;
    logic [WIDTH-1:0] hi_q, lo_q, pend_hi, pend_lo;
    logic             pend_wr;
    logic [WIDTH-1:0] calc_hi, calc_lo;
    logic             calc_wr;
    logic             busy, accept, launch;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .hi_in  (hi_q),
        .lo_in  (lo_q),
        .hi_out (calc_hi),
        .lo_out (calc_lo),
        .wr     (calc_wr)
    );

    assign busy   = (cnt != 4'd0);
    // Any start while busy is dropped, so MTHI/MTLO never collide with a commit.
    assign accept = bus.start && !busy;
    assign launch = accept && is_launch_op(bus.op);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (launch) begin
            cnt     <= is_mul_op(bus.op) ? MUL_N : DIV_N;
            pend_hi <= calc_hi;
            pend_lo <= calc_lo;
            pend_wr <= calc_wr;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && pend_wr) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else if (accept && bus.op == OP_MTHI) begin
            hi_q <= bus.a;
        end else if (accept && bus.op == OP_MTLO) begin
            lo_q <= bus.a;
        end
    end

    always_comb begin
        bus.rd = '0;
        case (bus.op)
            OP_MFHI: bus.rd = hi_q;
            OP_MFLO: bus.rd = lo_q;
            default: ;
        endcase
    end

    assign bus.busy = busy;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
